// File: rtl/ctmm_pkg.sv
// Shared CTMM capability types: register layout, permission bit positions,
// fault codes and field accessors used by the SWITCH/SAVE/mLoad engines.
package ctmm_pkg;

    typedef struct packed {
        logic [63:0] word3_seal;
        logic [63:0] word2_limit;
        logic [63:0] word1_base;
        logic [63:0] word0_gt;
    } capability_reg_t;

    // Permission field lives in word0_gt[57:48]; these are bit indices within it.
    localparam int unsigned PERM_LSB   = 48;
    localparam int unsigned PERM_WIDTH = 10;
    localparam int unsigned PERM_L     = 4;
    localparam int unsigned PERM_S     = 5;

    typedef enum logic [2:0] {
        FAULT_NONE    = 3'd0,
        FAULT_PERM    = 3'd1,
        FAULT_BOUNDS  = 3'd2,
        FAULT_TIMEOUT = 3'd3
    } fault_type_t;

    function automatic logic [63:0] get_word0_gt(input capability_reg_t cap);
        return cap.word0_gt;
    endfunction

    function automatic logic [63:0] get_word1_base(input capability_reg_t cap);
        return cap.word1_base;
    endfunction

    function automatic logic [63:0] get_word2_limit(input capability_reg_t cap);
        return cap.word2_limit;
    endfunction

    function automatic logic [PERM_WIDTH-1:0] get_perms(input capability_reg_t cap);
        return cap.word0_gt[PERM_LSB +: PERM_WIDTH];
    endfunction

endpackage

// File: rtl/ctmm_save.sv
// SAVE engine: reads CR8+target and writes its GT word into the C-List held
// in CRd at a bounded index, through a single-beat acknowledged write channel.
module ctmm_save
    import ctmm_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            save_start,
    input  logic [2:0]      cr_dst,
    input  logic [2:0]      target,
    input  logic [9:0]      index,
    output logic            save_busy,
    output logic            save_complete,
    output logic            save_fault,
    output fault_type_t     fault_type,
    output logic [3:0]      cr_rd_addr,
    input  capability_reg_t cr_rd_data,
    output logic [63:0]     mem_addr,
    output logic            mem_wr_en,
    output logic [63:0]     mem_wr_data,
    input  logic            mem_wr_ack
);

    typedef enum logic [2:0] {
        IDLE,
        RD_CL_ADDR,
        RD_CL_DATA,
        CHECK,
        RD_SYS_ADDR,
        RD_SYS_DATA,
        WRITE
    } state_t;

    localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);

    state_t       state_reg, state_next;
    logic [2:0]   cr_dst_reg, cr_dst_next;
    logic [2:0]   target_reg, target_next;
    logic [9:0]   index_reg, index_next;
    logic [63:0]  cl_base_reg, cl_base_next;
    logic [63:0]  cl_limit_reg, cl_limit_next;
    logic         cl_perm_s_reg, cl_perm_s_next;
    logic [15:0]  ack_cnt_reg, ack_cnt_next;
    logic         complete_reg, complete_next;
    logic         fault_reg, fault_next;
    fault_type_t  fault_type_reg, fault_type_next;
    logic [63:0]  mem_addr_reg, mem_addr_next;
    logic [63:0]  mem_wr_data_reg, mem_wr_data_next;
    logic [PERM_WIDTH-1:0] cr_perms;
    logic         unused_cr_bits;

    assign cr_perms       = get_perms(cr_rd_data);
    assign unused_cr_bits = ^cr_rd_data.word3_seal;

    always_comb begin
        state_next       = state_reg;
        cr_dst_next      = cr_dst_reg;
        target_next      = target_reg;
        index_next       = index_reg;
        cl_base_next     = cl_base_reg;
        cl_limit_next    = cl_limit_reg;
        cl_perm_s_next   = cl_perm_s_reg;
        ack_cnt_next     = ack_cnt_reg;
        complete_next    = 1'b0;
        fault_next       = 1'b0;
        fault_type_next  = fault_type_reg;
        mem_addr_next    = mem_addr_reg;
        mem_wr_data_next = mem_wr_data_reg;
        cr_rd_addr       = 4'd0;
        mem_wr_en        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (save_start) begin
                    cr_dst_next     = cr_dst;
                    target_next     = target;
                    index_next      = index;
                    fault_type_next = FAULT_NONE;
                    state_next      = RD_CL_ADDR;
                end
            end
            RD_CL_ADDR: begin
                cr_rd_addr = {1'b0, cr_dst_reg};
                state_next = RD_CL_DATA;
            end
            RD_CL_DATA: begin
                cl_base_next   = get_word1_base(cr_rd_data);
                cl_limit_next  = get_word2_limit(cr_rd_data);
                cl_perm_s_next = cr_perms[PERM_S];
                state_next     = CHECK;
            end
            CHECK: begin
                if (!cl_perm_s_reg) begin
                    fault_next      = 1'b1;
                    fault_type_next = FAULT_PERM;
                    state_next      = IDLE;
                end else if ({54'd0, index_reg} >= cl_limit_reg) begin
                    fault_next      = 1'b1;
                    fault_type_next = FAULT_BOUNDS;
                    state_next      = IDLE;
                end else begin
                    state_next = RD_SYS_ADDR;
                end
            end
            RD_SYS_ADDR: begin
                cr_rd_addr = 4'd8 + {1'b0, target_reg};
                state_next = RD_SYS_DATA;
            end
            RD_SYS_DATA: begin
                // Entries are 8 bytes; the sum wraps silently at 2^64.
                mem_wr_data_next = get_word0_gt(cr_rd_data);
                mem_addr_next    = cl_base_reg + {51'd0, index_reg, 3'b000};
                ack_cnt_next     = 16'd0;
                state_next       = WRITE;
            end
            WRITE: begin
                mem_wr_en = 1'b1;
                if (mem_wr_ack) begin
                    complete_next = 1'b1;
                    state_next    = IDLE;
                end else if (ack_cnt_reg == ACK_LAST) begin
                    fault_next      = 1'b1;
                    fault_type_next = FAULT_TIMEOUT;
                    state_next      = IDLE;
                end else begin
                    ack_cnt_next = ack_cnt_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cr_dst_reg      <= 3'd0;
            target_reg      <= 3'd0;
            index_reg       <= 10'd0;
            cl_base_reg     <= 64'd0;
            cl_limit_reg    <= 64'd0;
            cl_perm_s_reg   <= 1'b0;
            ack_cnt_reg     <= 16'd0;
            complete_reg    <= 1'b0;
            fault_reg       <= 1'b0;
            fault_type_reg  <= FAULT_NONE;
            mem_addr_reg    <= 64'd0;
            mem_wr_data_reg <= 64'd0;
        end else begin
            state_reg       <= state_next;
            cr_dst_reg      <= cr_dst_next;
            target_reg      <= target_next;
            index_reg       <= index_next;
            cl_base_reg     <= cl_base_next;
            cl_limit_reg    <= cl_limit_next;
            cl_perm_s_reg   <= cl_perm_s_next;
            ack_cnt_reg     <= ack_cnt_next;
            complete_reg    <= complete_next;
            fault_reg       <= fault_next;
            fault_type_reg  <= fault_type_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wr_data_reg <= mem_wr_data_next;
        end
    end

    assign save_busy     = (state_reg != IDLE);
    assign save_complete = complete_reg;
    assign save_fault    = fault_reg;
    assign fault_type    = fault_type_reg;
    assign mem_addr      = mem_addr_reg;
    assign mem_wr_data   = mem_wr_data_reg;

endmodule

// File: tb/tb_ctmm_save.sv
// Self-checking bench for ctmm_save: directed and randomized SAVE transactions
// compared against an outcome/timing model derived from the capability rules.
module tb_ctmm_save;
    import ctmm_pkg::*;

    localparam int T = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            save_start = 1'b0;
    logic [2:0]      cr_dst = 3'd0;
    logic [2:0]      target = 3'd0;
    logic [9:0]      index = 10'd0;
    logic            save_busy;
    logic            save_complete;
    logic            save_fault;
    fault_type_t     fault_type;
    logic [3:0]      cr_rd_addr;
    capability_reg_t cr_rd_data = '0;
    logic [63:0]     mem_addr;
    logic            mem_wr_en;
    logic [63:0]     mem_wr_data;
    logic            mem_wr_ack = 1'b0;

    capability_reg_t regs [16];
    int              n_assert = 0;
    int              n_fail = 0;
    fault_type_t     last_fault = FAULT_NONE;

    ctmm_save #(.ACK_TIMEOUT(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .save_start   (save_start),
        .cr_dst       (cr_dst),
        .target       (target),
        .index        (index),
        .save_busy    (save_busy),
        .save_complete(save_complete),
        .save_fault   (save_fault),
        .fault_type   (fault_type),
        .cr_rd_addr   (cr_rd_addr),
        .cr_rd_data   (cr_rd_data),
        .mem_addr     (mem_addr),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ack   (mem_wr_ack)
    );

    always #5 clk = ~clk;

    // Capability register file: data valid one cycle after the address.
    always @(posedge clk) cr_rd_data <= regs[cr_rd_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic capability_reg_t mk(input logic [63:0] gt, input logic [63:0] base,
                                           input logic [63:0] limit);
        capability_reg_t c;
        c.word3_seal  = 64'h5EA1_5EA1_5EA1_5EA1;
        c.word2_limit = limit;
        c.word1_base  = base;
        c.word0_gt    = gt;
        return c;
    endfunction

    function automatic logic [63:0] s_gt(input logic [63:0] low);
        logic [63:0] g;
        g = low;
        g[48 + PERM_S] = 1'b1;
        return g;
    endfunction

    // One transaction starting at the current negedge (cycle 0). ack_at: index of the
    // write cycle in which to ack, or -1 for never. noise: extra starts while busy.
    task automatic run_save(input logic [2:0] d, input logic [2:0] t, input logic [9:0] idx,
                            input int ack_at, input bit noise);
        capability_reg_t cl, sys;
        fault_type_t exp_kind;
        int exp_cycle, exp_wr, c, wr_cycles, first_wr, pulse_cycle;
        bit done, exp_ok, got_complete;
        logic [63:0] exp_addr, exp_data;
        fault_type_t got_type;

        cl  = regs[d];
        sys = regs[8 + int'(t)];
        exp_addr = cl.word1_base + 64'(idx) * 64'd8;
        exp_data = sys.word0_gt;
        exp_ok = 1'b0;
        if (!cl.word0_gt[48 + PERM_S]) begin
            exp_kind = FAULT_PERM; exp_cycle = 4; exp_wr = 0;
        end else if (64'(idx) >= cl.word2_limit) begin
            exp_kind = FAULT_BOUNDS; exp_cycle = 4; exp_wr = 0;
        end else if (ack_at < 0 || ack_at >= T) begin
            exp_ok = 1'b1; exp_kind = FAULT_TIMEOUT; exp_cycle = 6 + T; exp_wr = T;
        end else begin
            exp_ok = 1'b1; exp_kind = FAULT_NONE; exp_cycle = 7 + ack_at; exp_wr = ack_at + 1;
        end

        chk("fault_type_hold_c0", 64'(fault_type), 64'(last_fault));
        save_start = 1'b1; cr_dst = d; target = t; index = idx; mem_wr_ack = 1'b0;
        c = 0; wr_cycles = 0; first_wr = -1; done = 1'b0; pulse_cycle = -1;
        got_complete = 1'b0; got_type = FAULT_NONE;
        while (!done && c < 60) begin
            step();
            c++;
            save_start = noise && (c == 2 || c == 3);
            if (noise) begin
                cr_dst = 3'($urandom); target = 3'($urandom); index = 10'($urandom);
            end
            mem_wr_ack = 1'b0;
            if (c == 1) begin
                chk("busy_c1", save_busy, 1);
                chk("cl_rd_addr", cr_rd_addr, {61'd0, d});
                chk("fault_type_cleared", 64'(fault_type), 64'(FAULT_NONE));
            end
            if (c == 4 && exp_ok) chk("sys_rd_addr", cr_rd_addr, 64'(8 + int'(t)));
            if (mem_wr_en) begin
                if (first_wr < 0) begin
                    first_wr = c;
                    chk("mem_addr", mem_addr, exp_addr);
                    chk("mem_wr_data", mem_wr_data, exp_data);
                end
                if (wr_cycles == ack_at) mem_wr_ack = 1'b1;
                wr_cycles++;
            end
            if (save_complete || save_fault) begin
                done = 1'b1;
                pulse_cycle = c;
                got_complete = save_complete;
                got_type = fault_type;
                chk("both_pulses", save_complete & save_fault, 0);
                chk("busy_at_pulse", save_busy, 0);
            end
        end
        save_start = 1'b0;
        mem_wr_ack = 1'b0;
        chk("tx_finished", done, 1);
        chk("pulse_cycle", 64'(pulse_cycle), 64'(exp_cycle));
        chk("complete_vs_fault", got_complete, exp_kind == FAULT_NONE);
        chk("fault_type", 64'(got_type), 64'(exp_kind));
        chk("write_cycles", 64'(wr_cycles), 64'(exp_wr));
        if (exp_wr > 0) chk("first_write_cycle", 64'(first_wr), 64'd6);
        $display("tx cr%0d target=%0d idx=%0d ack_at=%0d -> kind=%0d cycle=%0d writes=%0d",
                 d, t, idx, ack_at, got_type, pulse_cycle, wr_cycles);
        last_fault = exp_kind;
    endtask

    initial begin
        int wc;
        for (int i = 0; i < 16; i++) regs[i] = mk(64'(i) * 64'h1111, 64'd0, 64'd0);

        repeat (2) @(negedge clk);
        chk("rst_busy", save_busy, 0);
        chk("rst_complete", save_complete, 0);
        chk("rst_fault", save_fault, 0);
        chk("rst_fault_type", 64'(fault_type), 64'(FAULT_NONE));
        chk("rst_cr_rd_addr", cr_rd_addr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wr_en", mem_wr_en, 0);
        chk("rst_mem_wr_data", mem_wr_data, 0);
        rst_n = 1'b1;
        step();

        // Basic store, permission fault, bounds edge, timeout and late ack.
        regs[2] = mk(s_gt(64'd0), 64'h1000, 64'd16);
        regs[8] = mk(64'hA5, 64'd0, 64'd0);
        run_save(3'd2, 3'd0, 10'd5, 0, 1'b0);
        regs[3] = mk(64'h0000_0000_0000_1234, 64'h1000, 64'd16);
        run_save(3'd3, 3'd0, 10'd5, 0, 1'b0);
        run_save(3'd2, 3'd0, 10'd16, 0, 1'b0);
        run_save(3'd2, 3'd0, 10'd15, 0, 1'b0);
        run_save(3'd2, 3'd0, 10'd1, -1, 1'b0);
        run_save(3'd2, 3'd0, 10'd1, 3, 1'b0);
        regs[15] = mk(64'hFEED_FACE_CAFE_BEEF, 64'd0, 64'd0);
        run_save(3'd2, 3'd7, 10'd9, 1, 1'b1);
        regs[4] = mk(s_gt(64'd0), 64'hFFFF_FFFF_FFFF_FFF0, 64'd1024);
        run_save(3'd4, 3'd7, 10'd1023, 2, 1'b0);

        // Reset in the middle of a write.
        step();
        save_start = 1'b1; cr_dst = 3'd2; target = 3'd0; index = 10'd3;
        step();
        save_start = 1'b0;
        wc = 0;
        while (wc < 2 && n_assert < 100000) begin
            step();
            if (mem_wr_en) wc++;
            if (!mem_wr_en && wc == 0 && save_fault) break;
        end
        chk("reached_write", 64'(wc), 2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr_en", mem_wr_en, 0);
        chk("rst_mid_busy", save_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_pulse_after_rst", save_complete | save_fault, 0);
        end
        last_fault = FAULT_NONE;
        run_save(3'd2, 3'd0, 10'd7, 0, 1'b0);

        // Randomized transactions.
        for (int n = 0; n < 24; n++) begin
            logic [2:0] d, t;
            logic [63:0] g;
            d = 3'($urandom);
            t = 3'($urandom);
            g = {$urandom, $urandom};
            g[48 + PERM_S] = ($urandom_range(0, 3) != 0);
            regs[d] = mk(g, {$urandom, $urandom}, 64'($urandom_range(0, 1100)));
            regs[8 + int'(t)] = mk({$urandom, $urandom}, 64'd0, 64'd0);
            run_save(d, t, 10'($urandom_range(0, 1023)), $urandom_range(0, 5) - 1,
                     1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
